// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data memory: access size encodings, FSM states,
// wait-state limits and the address alignment helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WAIT_STATES_MAX = 15;
    localparam int CNT_W           = 4;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

    // Drops the low address bits a half or word access cannot use.
    function automatic logic [1:0] aligned_offset(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] res;
        res = off;
        if (size == SIZE_HALF) res = {off[1], 1'b0};
        if (size == SIZE_WORD) res = 2'b00;
        return res;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Lane steering for one 32-bit memory word: byte-enable generation and store merge,
// plus load extraction with sign or zero extension.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [3:0]  byte_en;
    logic [31:0] wpat;
    logic [31:0] shifted;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        byte_en   = 4'b0000;
        wpat      = wdata;
        load_data = '0;
        shifted   = old_word >> {offset, 3'b000};
        case (size_e'(size))
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << offset;
                wpat      = {4{wdata[7:0]}};
                load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                wpat      = {2{wdata[15:0]}};
                load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            end
            SIZE_WORD: begin
                byte_en   = 4'b1111;
                load_data = old_word;
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            new_word[8*i +: 8] = byte_en[i] ? wpat[8*i +: 8] : old_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/lsu_data_mem.sv
// Word-organised data memory behind a load/store request port with a fixed wait-state count.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module lsu_data_mem
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               IDX_W     = $clog2(DEPTH_WORDS);
    localparam int               AW        = IDX_W + 2;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             unsigned_q, unsigned_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             in_idle, cur_we, cur_unsigned, misalign, access_err, commit, mem_we;
    logic [1:0]       cur_size, cur_off, eff_off;
    logic [AW-1:0]    cur_addr;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_wdata, old_word, new_word, load_data;
    logic             unused_addr_hi;

    // With zero wait states the commit happens on the acceptance edge, so the live
    // request feeds the datapath in IDLE and the latched copy does everywhere else.
    assign in_idle      = (state_q == IDLE);
    assign cur_we       = in_idle ? req_we            : we_q;
    assign cur_size     = in_idle ? req_size          : size_q;
    assign cur_unsigned = in_idle ? req_unsigned      : unsigned_q;
    assign cur_addr     = in_idle ? req_addr[AW-1:0]  : addr_q;
    assign cur_wdata    = in_idle ? req_wdata         : wdata_q;
    assign cur_idx      = cur_addr[AW-1:2];
    assign cur_off      = cur_addr[1:0];
    assign unused_addr_hi = ^req_addr[31:AW];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(cur_size, cur_off);
    assign eff_off  = cur_off;
`else
    assign misalign = 1'b0;
    assign eff_off  = aligned_offset(cur_size, cur_off);
`endif

    assign access_err = (cur_size == SIZE_RSVD) || misalign;
    assign commit     = in_idle ? (req_valid && (WAIT_STATES == 0))
                                : ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    assign mem_we     = commit && cur_we && !access_err;
    assign old_word   = mem_q[cur_idx];

    lsu_byte_lane u_lane (
        .size        (cur_size),
        .is_unsigned (cur_unsigned),
        .offset      (eff_off),
        .wdata       (cur_wdata),
        .old_word    (old_word),
        .new_word    (new_word),
        .load_data   (load_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = commit;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr[AW-1:0];
                    wdata_d    = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_err_d   = access_err;
            rsp_rdata_d = (access_err || cur_we) ? 32'h0 : load_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // NOTE: the array is cleared on reset, which forces it into flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[cur_idx] <= new_word;
        end
    end

    assign req_ready = in_idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
